// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, one quotient bit per cycle; define SEQ_DIV_SIGNED_EN for two's-complement operands
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic r_dz;
  logic [WIDTH:0] w_shift, w_trial;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fix_q, w_fix_r;
  logic w_accept;
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign o_busy = r_state != IDLE;
`ifdef SEQ_DIV_SIGNED_EN
  logic r_a_neg, r_b_neg;
  assign w_a_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_b_mag = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
  assign w_fix_q = r_dz ? '1 : ((r_a_neg ^ r_b_neg) ? -r_quo : r_quo);
  assign w_fix_r = r_dz ? (r_a_neg ? -r_quo : r_quo) : (r_a_neg ? -r_rem : r_rem);
  // operand signs, kept for the sign correction after the magnitude divide
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {r_a_neg, r_b_neg} <= 2'b00;
    else if (w_accept) {r_a_neg, r_b_neg} <= {i_dividend[WIDTH-1], i_divisor[WIDTH-1]};
`else
  assign w_a_mag = i_dividend;
  assign w_b_mag = i_divisor;
  assign w_fix_q = r_dz ? '1 : r_quo;
  assign w_fix_r = r_dz ? r_quo : r_rem;
`endif
  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state; a zero divisor skips the iterations entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = i_start ? ((i_divisor == '0) ? FIX : CALC) : IDLE;
      CALC: w_next = (r_cnt == CW'(WIDTH - 1)) ? FIX : CALC;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: quotient register starts as the dividend magnitude and fills with quotient bits
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_dz <= 1'b0;
      o_quotient <= '0;
      o_remainder <= '0;
      o_div_by_zero <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= r_state == DONE;
      if (w_accept) begin
        r_rem <= '0;
        r_quo <= w_a_mag;
        r_dvs <= w_b_mag;
        r_cnt <= '0;
        r_dz <= i_divisor == '0;
      end
      if (r_state == CALC) begin
        r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIX) begin
        o_quotient <= w_fix_q;
        o_remainder <= w_fix_r;
        o_div_by_zero <= r_dz;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (either SEQ_DIV_SIGNED_EN build)
module tb_seq_divider;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] dvd = 0, dvs = 0;
  logic busy, done, dz;
  logic [31:0] q, r;
  typedef struct packed {logic [31:0] q; logic [31:0] r; logic dz;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dividend(dvd), .i_divisor(dvs),
    .o_busy(busy), .o_done(done), .o_quotient(q), .o_remainder(r), .o_div_by_zero(dz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dz = (b == 0);
    if (b == 0) begin e.q = '1; e.r = a; end
`ifdef SEQ_DIV_SIGNED_EN
    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin e.q = 32'h80000000; e.r = 0; end
    else begin e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); end
`else
    else begin e.q = a / b; e.r = a % b; end
`endif
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dvd = a; dvs = b; start = 1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 0; dvd = $urandom; dvs = $urandom;
  endtask

  task automatic wait_done(output int n, output int gaps);
    n = 0; gaps = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) gaps++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h want=0", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_r got=%h want=0", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", dz); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n, g;
    exp_t e;
    issue(100, 7);
    wait_done(n, g);
    e = sb.pop_front();
    checks++; if (n != 34) begin errors++; $display("FAIL basic_latency got=%0d want=34", n); end
    checks++; if (g != 0) begin errors++; $display("FAIL basic_busy_gaps got=%0d want=0", g); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    checks++; if (q !== e.q || q !== 32'd14) begin errors++; $display("FAIL basic_q got=%h want=%h", q, e.q); end
    checks++; if (r !== e.r || r !== 32'd2) begin errors++; $display("FAIL basic_r got=%h want=%h", r, e.r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b want=0", dz); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++; $display("FAIL basic_hold got=%h/%h want=e/2", q, r); end
  endtask

  task automatic test_patterns;
    logic [31:0] ta[10] = '{100, -100, 100, -100, 32'h1234, 32'h80000000, 32'hFFFFFFFF, 0, 5, 32'hDEADBEEF};
    logic [31:0] tb[10] = '{7, 7, -7, -7, 0, 32'hFFFFFFFF, 1, 5, 9, 32'h10};
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      int n, g;
      exp_t e;
      a = (i < 10) ? ta[i] : $urandom;
      b = (i < 10) ? tb[i] : ((i % 2) ? ($urandom & 32'hFF) : $urandom);
      issue(a, b);
      wait_done(n, g);
      e = sb.pop_front();
      checks++; if (n != ((b == 0) ? 2 : 34)) begin errors++; $display("FAIL pat%0d_latency got=%0d want=%0d", i, n, (b == 0) ? 2 : 34); end
      checks++; if (q !== e.q) begin errors++; $display("FAIL pat%0d_q %h/%h got=%h want=%h", i, a, b, q, e.q); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL pat%0d_r %h/%h got=%h want=%h", i, a, b, r, e.r); end
      checks++; if (dz !== e.dz) begin errors++; $display("FAIL pat%0d_dz got=%b want=%b", i, dz, e.dz); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_busy;
    int cnt = 0;
    exp_t e;
    issue(100, 7);
    e = sb.pop_front();
    repeat (9) @(negedge clk);
    start = 1; dvd = 50; dvs = 5;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        cnt++;
        checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL busy_start_result got=%h/%h want=%h/%h", q, r, e.q, e.r); end
      end
      @(negedge clk);
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL busy_start_done_count got=%0d want=1", cnt); end
  endtask

  task automatic test_reset_mid;
    int cnt = 0, n, g;
    exp_t e;
    issue(100, 7);
    repeat (14) @(negedge clk);
    @(posedge clk);
    rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got=%b%b want=00", busy, done); end
    checks++; if (q !== 0 || r !== 0 || dz !== 1'b0) begin errors++; $display("FAIL midrst_data got=%h/%h/%b want=0/0/0", q, r, dz); end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", cnt); end
    issue(9, 3);
    wait_done(n, g);
    e = sb.pop_front();
    checks++; if (n != 34) begin errors++; $display("FAIL midrst_latency got=%0d want=34", n); end
    checks++; if (q !== 32'd3 || q !== e.q || r !== 32'd0) begin errors++; $display("FAIL midrst_result got=%h/%h want=3/0", q, r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ta[4] = '{1000, 7, 77, -1};
    logic [31:0] tb[4] = '{10, 0, 7, 2};
    for (int i = 0; i < 4; i++) begin
      int n, g;
      exp_t e;
      issue(ta[i], tb[i]);
      wait_done(n, g);
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL b2b%0d_scoreboard got=empty want=entry", i);
      end else begin
        e = sb.pop_front();
        checks++; if (n != ((tb[i] == 0) ? 2 : 34) || g != 0) begin errors++; $display("FAIL b2b%0d_timing got=%0d/%0d want=%0d/0", i, n, g, (tb[i] == 0) ? 2 : 34); end
        checks++; if (q !== e.q || r !== e.r || dz !== e.dz) begin errors++; $display("FAIL b2b%0d_result got=%h/%h/%b want=%h/%h/%b", i, q, r, dz, e.q, e.r, e.dz); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_patterns;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
